// File: rtl/wb_rr_arbiter.sv
// Two-master / one-slave Wishbone arbiter: round-robin grant between m0 and m1,
// with a watchdog that turns a stalled slave transfer into an error on the owner.
module wb_rr_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat;
    logic                  we;
    logic [SW-1:0]         sel;
    logic                  stb;
    logic                  cyc;
  } wb_req_t;

  typedef enum logic [2:0] {IDLE, BUS0, BUS1, ABORT0, ABORT1} state_t;

  state_t          state, state_nxt;
  logic            last, last_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  wb_req_t [1:0]   req;
  wb_req_t         sreq;
  logic            own, bus, abort, s_resp, wd_fire;

  assign req[0] = '{adr: m0_adr_i, dat: m0_dat_i, we: m0_we_i, sel: m0_sel_i,
                    stb: m0_stb_i, cyc: m0_cyc_i};
  assign req[1] = '{adr: m1_adr_i, dat: m1_dat_i, we: m1_we_i, sel: m1_sel_i,
                    stb: m1_stb_i, cyc: m1_cyc_i};

  assign bus    = (state == BUS0)   || (state == BUS1);
  assign abort  = (state == ABORT0) || (state == ABORT1);
  assign own    = (state == BUS1)   || (state == ABORT1);
  assign s_resp = s_ack_i | s_err_i;

  // A slave response in the final allowed cycle wins over the abort.
  assign wd_fire = (TIMEOUT_CYCLES != 0) && bus && sreq.stb && !s_resp && (cnt == TO_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req[0].cyc && req[1].cyc) state_nxt = last ? BUS0 : BUS1;
        else if (req[0].cyc)          state_nxt = BUS0;
        else if (req[1].cyc)          state_nxt = BUS1;
      end
      BUS0, BUS1: begin
        if (!req[own].cyc) begin
          state_nxt = IDLE;
          last_nxt  = own;
          cnt_nxt   = '0;
        end else if (wd_fire) begin
          state_nxt = own ? ABORT1 : ABORT0;
          cnt_nxt   = '0;
        end else if (s_resp || TIMEOUT_CYCLES == 0) begin
          cnt_nxt = '0;
        end else if (sreq.stb && cnt != CNT_MAX) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ABORT0, ABORT1: begin
        cnt_nxt = '0;
        if (req[own].cyc) begin
          state_nxt = own ? BUS1 : BUS0;
        end else begin
          state_nxt = IDLE;
          last_nxt  = own;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Slave side follows the owner only while in BUSx; IDLE and ABORTx park it at zero.
  assign sreq    = bus ? req[own] : '0;
  assign s_adr_o = sreq.adr;
  assign s_dat_o = sreq.dat;
  assign s_we_o  = sreq.we;
  assign s_sel_o = sreq.sel;
  assign s_stb_o = sreq.stb;
  assign s_cyc_o = sreq.cyc;

  assign grant_o   = {(state == BUS1) || (state == ABORT1), (state == BUS0) || (state == ABORT0)};
  assign timeout_o = abort;

  logic [1:0][DATA_WIDTH-1:0] m_dat;
  logic [1:0]                 m_ack, m_err;

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    logic mine;
    assign mine     = (own == 1'(i)) && (bus || abort);
    assign m_dat[i] = (mine && bus) ? s_dat_i : '0;
    assign m_ack[i] = mine && bus && s_ack_i && !s_err_i;
    assign m_err[i] = mine && (abort || s_err_i);
  end

  assign m0_dat_o = m_dat[0];
  assign m0_ack_o = m_ack[0];
  assign m0_err_o = m_err[0];
  assign m1_dat_o = m_dat[1];
  assign m1_ack_o = m_ack[1];
  assign m1_err_o = m_err[1];

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with an 8-cycle watchdog.
module tb_wb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  logic [3:0]  m0_sel, m1_sel;
  logic        s_ack, s_err;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_we_o, s_stb_o, s_cyc_o, timeout_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;

  int tests = 0;
  int fails = 0;

  wb_rr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int m, input logic cyc, input logic we,
                     input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = 4'hF;
    end else begin
      m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = 4'hF;
    end
  endtask

  initial begin
    rst = 1'b1;
    req(0, 1'b0, 1'b0, '0, '0);
    req(1, 1'b0, 1'b0, '0, '0);
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_s_cyc", s_cyc_o, 1'b0);
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("rst_m0_err", m0_err_o, 1'b0);
    rst = 1'b0;

    // m0 single read, slave acks on the third bus cycle
    tick();
    req(0, 1'b1, 1'b0, 32'h8000_0010, '0);
    #1 chk("rd_cyc_latency", s_cyc_o, 1'b0);
    tick();
    chk("rd_s_cyc", s_cyc_o, 1'b1);
    chk("rd_s_adr", s_adr_o, 32'h8000_0010);
    chk("rd_grant", grant_o, 2'b01);
    tick(); tick();
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    #1 chk("rd_m0_ack", m0_ack_o, 1'b1);
    chk("rd_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
    chk("rd_m1_ack", m1_ack_o, 1'b0);
    chk("rd_m1_dat", m1_dat_o, 32'h0);
    tick();
    s_ack = 1'b0; s_dat = '0;
    req(0, 1'b0, 1'b0, '0, '0);
    #1 chk("rd_ack_drop", m0_ack_o, 1'b0);
    tick();
    chk("rd_idle_grant", grant_o, 2'b00);

    // Reset again so last = 1, then simultaneous writes
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    req(0, 1'b1, 1'b1, 32'h0000_00A0, 32'h1111_1111);
    req(1, 1'b1, 1'b1, 32'h0000_00B0, 32'h2222_2222);
    tick();
    chk("tie_grant_m0", grant_o, 2'b01);
    chk("tie_s_dat_m0", s_dat_o, 32'h1111_1111);
    chk("tie_s_we", s_we_o, 1'b1);
    s_ack = 1'b1;
    #1 chk("tie_m0_ack", m0_ack_o, 1'b1);
    chk("tie_m1_waits", m1_ack_o, 1'b0);
    tick();
    s_ack = 1'b0;
    req(0, 1'b0, 1'b0, '0, '0);
    tick();
    chk("tie_idle_grant", grant_o, 2'b00);
    chk("tie_idle_cyc", s_cyc_o, 1'b0);
    tick();
    chk("tie_grant_m1", grant_o, 2'b10);
    chk("tie_s_adr_m1", s_adr_o, 32'h0000_00B0);
    s_ack = 1'b1;
    #1 chk("tie_m1_ack", m1_ack_o, 1'b1);
    chk("tie_m0_quiet", m0_ack_o, 1'b0);
    tick();
    s_ack = 1'b0;
    req(1, 1'b0, 1'b0, '0, '0);
    tick();

    // Continuous re-requests: ownership alternates m0, m1, m0, ...
    req(0, 1'b1, 1'b0, 32'h100, '0);
    req(1, 1'b1, 1'b0, 32'h200, '0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr_grant_%0d", k), grant_o, (k % 2) ? 2'b10 : 2'b01);
      s_ack = 1'b1;
      #1 chk($sformatf("rr_ack_%0d", k), (k % 2) ? m1_ack_o : m0_ack_o, 1'b1);
      tick();
      s_ack = 1'b0;
      req(k % 2, 1'b0, 1'b0, '0, '0);
      tick();
      req(k % 2, 1'b1, 1'b0, (k % 2) ? 32'h200 : 32'h100, '0);
    end
    req(0, 1'b0, 1'b0, '0, '0);
    req(1, 1'b0, 1'b0, '0, '0);
    tick();

    // Watchdog: m1 write never acked, abort after 8 stalled strobe cycles
    req(1, 1'b1, 1'b1, 32'h300, 32'h3333_3333);
    tick();
    chk("wd_grant", grant_o, 2'b10);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("wd_no_to_%0d", c), timeout_o, 1'b0);
      tick();
    end
    chk("wd_timeout", timeout_o, 1'b1);
    chk("wd_m1_err", m1_err_o, 1'b1);
    chk("wd_m1_ack", m1_ack_o, 1'b0);
    chk("wd_s_cyc", s_cyc_o, 1'b0);
    chk("wd_abort_grant", grant_o, 2'b10);
    req(1, 1'b0, 1'b0, '0, '0);
    tick();
    chk("wd_idle_grant", grant_o, 2'b00);
    chk("wd_to_pulse", timeout_o, 1'b0);
    chk("wd_err_pulse", m1_err_o, 1'b0);

    // Ack on the last allowed cycle beats the watchdog
    req(1, 1'b1, 1'b1, 32'h300, 32'h3333_3333);
    tick();
    for (int c = 0; c < 7; c++) tick();
    s_ack = 1'b1;
    #1 chk("wd_late_ack", m1_ack_o, 1'b1);
    tick();
    s_ack = 1'b0;
    chk("wd_no_abort", timeout_o, 1'b0);
    chk("wd_still_bus", s_cyc_o, 1'b1);
    req(1, 1'b0, 1'b0, '0, '0);
    tick();

    // Simultaneous ack and err on an m0 read
    req(0, 1'b1, 1'b0, 32'h400, '0);
    tick();
    s_ack = 1'b1; s_err = 1'b1;
    #1 chk("ae_m0_err", m0_err_o, 1'b1);
    chk("ae_m0_ack", m0_ack_o, 1'b0);
    tick();
    s_ack = 1'b0; s_err = 1'b0;
    req(0, 1'b0, 1'b0, '0, '0);
    tick();

    // Asynchronous reset in the middle of an m1 transfer
    req(1, 1'b1, 1'b0, 32'h500, '0);
    tick();
    chk("ar_grant", grant_o, 2'b10);
    s_ack = 1'b1;
    #1 chk("ar_pre_ack", m1_ack_o, 1'b1);
    rst = 1'b1;
    #1 chk("ar_m1_ack", m1_ack_o, 1'b0);
    chk("ar_s_cyc", s_cyc_o, 1'b0);
    chk("ar_s_adr", s_adr_o, 32'h0);
    chk("ar_grant0", grant_o, 2'b00);
    s_ack = 1'b0;
    req(0, 1'b1, 1'b0, 32'h600, '0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_m0_wins", grant_o, 2'b01);
    req(0, 1'b0, 1'b0, '0, '0);
    req(1, 1'b0, 1'b0, '0, '0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
